// File: rtl/log2_pkg.sv
// Shared types and constants for the iterative fixed-point log2 unit.
// Holds the FSM state enum and the Q1.15 mantissa type.
package log2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

    localparam int INT_W  = 5;
    localparam int MANT_W = 16;

    typedef logic [MANT_W-1:0] mant_t;

endpackage

// File: rtl/log2.sv
// Combinational MSB finder: log2 = index of highest set bit of A.
// An all-zero operand reports 0.
module log2 (
    input  logic [31:0] A,
    output logic [4:0]  log2
);

    always_comb begin
        log2 = '0;
        for (int i = 0; i < 32; i++) begin
            if (A[i]) log2 = i[4:0];
        end
    end

endmodule

// File: rtl/log2_frac_iter.sv
// Iterative fixed-point log2: integer part from log2, fraction by squaring.
// Optional round-half-up with saturation via `define LOG2_FRAC_ROUND_EN.
module log2_frac_iter
    import log2_pkg::*;
#(
    parameter int FRAC_BITS = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INT_W+FRAC_BITS-1:0] out_data,
    output logic                       out_zero
);

`ifdef LOG2_FRAC_ROUND_EN
    localparam int ITERS = FRAC_BITS + 1;
`else
    localparam int ITERS = FRAC_BITS;
`endif
    localparam int OUT_W = INT_W + FRAC_BITS;
    localparam int CNT_W = 5;

    state_t                   state_q, state_d;
    logic [INT_W-1:0]         e_in, e_q;
    logic [31:0]              shifted;
    mant_t                    m_in, m_q, m_nx;
    logic [31:0]              sq;
    logic                     sq_bit;
    logic [ITERS-1:0]         frac_q, frac_nx;
    logic [CNT_W-1:0]         cnt_q;
    logic                     last;
    logic [OUT_W-1:0]         res;
    logic [OUT_W-1:0]         data_q;
    logic                     zero_q;

    log2 u_log2 (
        .A    (in_data),
        .log2 (e_in)
    );

    // Normalise so the leading one lands in bit 31, keep top 16 bits.
    assign shifted = in_data << (5'd31 - e_in);
    assign m_in    = shifted[31:16];

    assign sq      = {16'b0, m_q} * {16'b0, m_q};
    assign sq_bit  = sq[31];
    assign m_nx    = sq_bit ? sq[31:16] : sq[30:15];
    assign frac_nx = (frac_q << 1) | ITERS'(sq_bit);
    assign last    = (cnt_q == CNT_W'(ITERS - 1));

`ifdef LOG2_FRAC_ROUND_EN
    logic [OUT_W:0] full;
    logic [OUT_W:0] sum;

    assign full = {e_q, frac_nx};
    assign sum  = {1'b0, full[OUT_W:1]} + {{OUT_W{1'b0}}, full[0]};
    // A carry out of the top means {e,frac} was all-ones: clamp.
    assign res  = sum[OUT_W] ? {OUT_W{1'b1}} : sum[OUT_W-1:0];
`else
    assign res  = {e_q, frac_nx};
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;
    assign out_zero  = zero_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = (in_data == 32'd0) ? DONE : ITER;
                end
            end
            ITER: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q    <= '0;
            m_q    <= '0;
            frac_q <= '0;
            cnt_q  <= '0;
            data_q <= '0;
            zero_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        e_q    <= e_in;
                        m_q    <= m_in;
                        frac_q <= '0;
                        cnt_q  <= '0;
                        zero_q <= (in_data == 32'd0);
                        if (in_data == 32'd0) data_q <= '0;
                    end
                end
                ITER: begin
                    m_q    <= m_nx;
                    frac_q <= frac_nx;
                    cnt_q  <= cnt_q + 1'b1;
                    if (last) data_q <= res;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_log2_frac_iter.sv
// Randomised self-checking bench for log2_frac_iter (FRAC_BITS=8).
// Honours LOG2_FRAC_ROUND_EN to match the build under test.
module tb_log2_frac_iter;

    localparam int FB = 8;
    localparam int OW = 5 + FB;
`ifdef LOG2_FRAC_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif
    localparam int LAT_NZ = FB + 1 + (RND ? 1 : 0);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] out_data;
    logic          out_zero;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    log2_frac_iter #(.FRAC_BITS(FB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    // Reference: log2(x) = e + log2(m), m in [1,2); each squaring of m
    // doubles its log, so the bit is 1 exactly when m*m reaches 2.
    function automatic int ref_log(input logic [31:0] x);
        int     e;
        int     n;
        longint m;
        longint f;
        longint r;
        if (x == 0) return 0;
        e = 0;
        for (int i = 0; i < 32; i++) if (x[i]) e = i;
        m = (longint'(x) * (longint'(1) << (31 - e))) / 65536;
        n = FB + (RND ? 1 : 0);
        f = 0;
        for (int k = 0; k < n; k++) begin
            m = m * m;
            if (m >= (longint'(1) << 31)) begin
                f = f * 2 + 1;
                m = m / 65536;
            end else begin
                f = f * 2;
                m = m / 32768;
            end
        end
        r = longint'(e) * (longint'(1) << n) + f;
        if (RND) begin
            r = (r + 1) / 2;
            if (r > (longint'(1) << OW) - 1) r = (longint'(1) << OW) - 1;
        end
        return int'(r);
    endfunction

    task automatic launch(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    // Counts edges from (and including) the accept edge to out_valid.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL release: out_valid=%b in_ready=%b want 0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic run_op(input logic [31:0] d, output logic [OW-1:0] q,
                          output logic z, output int lat);
        launch(d);
        wait_valid(lat);
        q = out_data;
        z = out_zero;
        release_out();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
            out_data !== '0 || out_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset: rdy=%b vld=%b data=%h zero=%b want 1/0/0/0",
                     in_ready, out_valid, out_data, out_zero);
        end
    endtask

    task automatic test_vectors();
        logic [31:0]   vec [6];
        logic [OW-1:0] want [6];
        logic [OW-1:0] q;
        logic          z;
        int            lat;
        vec[0] = 32'd1;          want[0] = 13'h000;
        vec[1] = 32'd3;          want[1] = RND ? 13'h196 : 13'h195;
        vec[2] = 32'h8000_0000;  want[2] = 13'h1F00;
        vec[3] = 32'd16;         want[3] = 13'h400;
        vec[4] = 32'd0;          want[4] = 13'h000;
        vec[5] = 32'hFFFF_FFFF;  want[5] = RND ? 13'h1FFF : OW'(ref_log(32'hFFFF_FFFF));
        for (int i = 0; i < 6; i++) begin
            run_op(vec[i], q, z, lat);
            checks++;
            if (q !== want[i] || z !== (vec[i] == 0) ||
                lat != ((vec[i] == 0) ? 1 : LAT_NZ)) begin
                failures++;
                $display("FAIL vector %h: data=%h zero=%b lat=%0d want %h/%b/%0d",
                         vec[i], q, z, lat, want[i], vec[i] == 0,
                         (vec[i] == 0) ? 1 : LAT_NZ);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0]   d;
        logic [OW-1:0] q;
        logic          z;
        int            lat;
        for (int i = 0; i < 40; i++) begin
            d = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 15) == 0) d = 0;
            run_op(d, q, z, lat);
            checks++;
            if (q !== OW'(ref_log(d)) || z !== (d == 0) ||
                lat != ((d == 0) ? 1 : LAT_NZ)) begin
                failures++;
                $display("FAIL random %h: data=%h zero=%b lat=%0d want %h/%b",
                         d, q, z, lat, OW'(ref_log(d)), d == 0);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [OW-1:0] held;
        int            lat;
        launch(32'd3);
        wait_valid(lat);
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 32'd7;
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL backpressure: vld=%b data=%h rdy=%b want 1/%h/0",
                         out_valid, out_data, in_ready, held);
            end
        end
        in_valid = 1'b0;
        release_out();
        checks++;
        if (held !== OW'(ref_log(32'd3)) || out_data !== held) begin
            failures++;
            $display("FAIL backpressure_data: held=%h now=%h want %h",
                     held, out_data, OW'(ref_log(32'd3)));
        end
    endtask

    task automatic test_reset_mid_iter();
        logic [OW-1:0] q;
        logic          z;
        int            lat;
        launch(32'd1000);
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 32'd5;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset: vld=%b rdy=%b want 0/1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_after: vld=%b rdy=%b want 0/1",
                     out_valid, in_ready);
        end
        run_op(32'd16, q, z, lat);
        checks++;
        if (q !== 13'h400 || z !== 1'b0 || lat != LAT_NZ) begin
            failures++;
            $display("FAIL post_reset: data=%h zero=%b lat=%0d want 400/0/%0d",
                     q, z, lat, LAT_NZ);
        end
    endtask

    task automatic test_back_to_back(input logic [31:0] d, input int want);
        int acc [$];
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        for (int c = 0; c < 40; c++) begin
            if (in_ready) acc.push_back(c);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (LAT_NZ + 2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (acc.size() < 3 || acc[1] - acc[0] != want || acc[2] - acc[1] != want) begin
            failures++;
            $display("FAIL back_to_back %h: accepts=%0d gap=%0d want gap %0d",
                     d, acc.size(), (acc.size() > 1) ? acc[1] - acc[0] : -1, want);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_backpressure();
        test_reset_mid_iter();
        test_back_to_back(32'd3, LAT_NZ + 1);
        test_back_to_back(32'd0, 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/log2_frac_iter.md
# log2_frac_iter

Iterative fixed-point log2 unit that sits directly downstream of the combinational `log2` MSB finder. It accepts a 32-bit unsigned operand over a valid/ready handshake and uses `log2` for the integer part. It then normalises the operand and produces FRAC_BITS fractional bits by repeated squaring, one bit per clock. The result is returned as unsigned fixed-point (5 integer bits, FRAC_BITS fraction bits) on an output valid/ready handshake.

## Interface
- FRAC_BITS, 8: number of fractional result bits; legal range 1..16.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand offered.
- in_ready  out  1  unit can accept an operand.
- in_data  in  32  unsigned operand.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  5+FRAC_BITS  {integer log2 [4:0], fraction [FRAC_BITS-1:0]}.
- out_zero  out  1  operand was 0; out_data is 0.

## Operation
- States: IDLE, ITER, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture the integer part e = `log2`(in_data).
  - Capture the mantissa m = top 16 bits of (in_data << (31-e)) as Q1.15, so m is in [1,2).
  - If in_data==0: out_zero<=1, result<=0, go to DONE. Otherwise clear the fraction register and counter, then go to ITER.
- ITER: each cycle, compute sq = m*m (32-bit, Q2.30).
  - If sq[31]: shift in bit 1, m<=sq[31:16].
  - Else: shift in bit 0, m<=sq[30:15].
  - The fraction shifts in MSB-first.
  - After FRAC_BITS iterations, go to DONE.
- DONE:
  - out_valid=1; out_data/out_zero are held stable.
  - On out_ready, go to IDLE.
- in_ready=0 in ITER and DONE. No operand overlap: a new accept is possible only from IDLE, on the cycle after the output handshake.
- Mantissa truncation is by bit-select only. The fraction is truncated unless rounding is compiled in.
- Reset at any time, including mid-ITER or while DONE is waiting for out_ready:
  - State returns to IDLE.
  - Any in-flight result is discarded; it is never presented.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_zero=0.
- Nonzero operand: out_valid rises FRAC_BITS+1 clock edges after the accept edge.
- Zero operand: out_valid rises 1 edge after the accept edge.
- Minimum accept-to-accept interval: FRAC_BITS+2 cycles (nonzero) or 2 cycles (zero), with out_ready held high.
- in_data is sampled only on the accept edge; it may change freely afterwards.
- out_valid stays high with stable data until the out_ready handshake. Handshakes are not combinationally dependent on each other.

## Configuration
- LOG2_FRAC_ROUND_EN defined:
  - Perform FRAC_BITS+1 iterations; latency becomes FRAC_BITS+2 edges.
  - Round half-up using the extra bit; a carry propagates into the integer field.
  - If {e,fraction} is all-ones, saturate to all-ones instead of wrapping.
- LOG2_FRAC_ROUND_EN undefined: FRAC_BITS iterations, truncated fraction.

## Structure
- Shared package `log2_pkg`:
  - state enum {IDLE, ITER, DONE}.
  - INT_W=5 and MANT_W=16 constants.
  - Q1.15 mantissa typedef.
- Sub-module: instantiate the existing combinational `log2` (ports A, log2) for the integer part and normalisation shift.
- The squarer is inline (16x16 multiply); no separate module.

## Test plan
All values below use FRAC_BITS=8.
- Reset then idle: in_ready=1, out_valid=0, out_data=0x000, out_zero=0.
- in_data=1:
  - out_data=0x000, out_zero=0.
  - out_valid after 9 edges (10 with LOG2_FRAC_ROUND_EN).
- in_data=3:
  - out_data=0x195 (int 1, frac 0x95) truncated.
  - out_data=0x196 with LOG2_FRAC_ROUND_EN.
- in_data=0x80000000 gives out_data=0x1F00; in_data=16 gives out_data=0x400.
- in_data=0: out_zero=1, out_data=0, out_valid one edge after accept.
- in_data=0xFFFFFFFF with LOG2_FRAC_ROUND_EN: out_data=0x1FFF (saturated).
- Backpressure: hold out_ready=0 for 5 cycles in DONE. out_data must stay stable and in_ready=0; in_valid offered during this window is not accepted.
- Assert rst mid-ITER with in_valid high: next cycle IDLE, out_valid=0. The next operand (in_data=16) yields 0x400 with normal latency.
